// File: rtl/fp_pkg.sv
// Shared Fp definitions for the SQIsign level-1 datapath: element type, modulus,
// Fp2 add/sub opcodes and the add/sub pipeline latency.
package fp_pkg;

    localparam int FP_W = 255;

    typedef logic [FP_W-1:0] fp_t;

    // p = 5 * 2^248 - 1
    localparam fp_t FP_P = (fp_t'(5) << 248) - fp_t'(1);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_DBL  = 2'b10,
        OP_CONJ = 2'b11
    } fp2_op_e;

    localparam int FP2_ADDSUB_LATENCY = 2;

endpackage

// File: rtl/fp_addsub_lane.sv
// One Fp lane of the Fp2 add/sub pipeline: stage 1 forms the raw WIDTH+1-bit
// sum/difference, stage 2 folds it back into [0, P-1].
module fp_addsub_lane
    import fp_pkg::*;
#(
    parameter int               WIDTH = FP_W,
    parameter logic [WIDTH-1:0] P     = WIDTH'(FP_P)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             is_conj_re,
    input  fp2_op_e          op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] d
);

    logic [WIDTH:0]   r_q, r_d;
    fp2_op_e          op_q, op_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH+1:0] t;
    logic [WIDTH:0]   xe, ye;

    assign xe = {1'b0, x};
    assign ye = {1'b0, y};

    // Stage 1: raw operation; bit WIDTH is the carry for additive ops and the
    // borrow for subtractive ones.
    always_comb begin
        r_d  = r_q;
        op_d = op_q;
        if (adv) begin
            op_d = op;
            case (op)
                OP_ADD:  r_d = xe + ye;
                OP_DBL:  r_d = xe + xe;
                OP_SUB:  r_d = xe - ye;
                OP_CONJ: r_d = is_conj_re ? xe : ({(WIDTH+1){1'b0}} - xe);
                default: r_d = xe;
            endcase
        end
    end

    // Stage 2: a single conditional correction suffices since inputs are < P.
    always_comb begin
        t   = {1'b0, r_q} - {2'b00, P};
        d_d = d_q;
        if (adv) begin
            case (op_q)
                OP_ADD, OP_DBL: d_d = t[WIDTH+1] ? WIDTH'(r_q) : WIDTH'(t);
                OP_CONJ: begin
                    if (is_conj_re)
                        d_d = WIDTH'(r_q);
                    else
                        d_d = r_q[WIDTH] ? WIDTH'(r_q + {1'b0, P}) : WIDTH'(r_q);
                end
                default: d_d = r_q[WIDTH] ? WIDTH'(r_q + {1'b0, P}) : WIDTH'(r_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            op_q <= OP_ADD;
            d_q  <= '0;
        end else begin
            r_q  <= r_d;
            op_q <= op_d;
            d_q  <= d_d;
        end
    end

    assign d = d_q;

endmodule

// File: rtl/fp2_addsub_pipe.sv
// Fully pipelined Fp2 add/sub/double/conjugate unit with valid/ready handshake,
// tag passthrough and a single global stall enable shared by all stages.
module fp2_addsub_pipe
    import fp_pkg::*;
#(
    parameter int               WIDTH = FP_W,
    parameter logic [WIDTH-1:0] P     = WIDTH'(fp_pkg::FP_P),
    parameter int               TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2
);

    localparam int LATENCY = FP2_ADDSUB_LATENCY;

    logic                adv;
    logic [LATENCY-1:0]  v_q, v_d;
    logic [TAG_W-1:0]    tag_q [LATENCY];
    logic [TAG_W-1:0]    tag_d [LATENCY];
    logic [WIDTH-1:0]    lane_x [2];
    logic [WIDTH-1:0]    lane_y [2];
    logic [WIDTH-1:0]    lane_d [2];

    // The whole pipe moves as one; a full output stage that is not being
    // drained freezes everything behind it.
    assign adv      = ~v_q[LATENCY-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        if (adv) begin
            v_d[0]   = in_valid;
            tag_d[0] = in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                v_d[i]   = v_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            v_q <= v_d;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign lane_x[0] = A1;
    assign lane_x[1] = A2;
    assign lane_y[0] = B1;
    assign lane_y[1] = B2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            fp_addsub_lane #(
                .WIDTH (WIDTH),
                .P     (P)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .adv        (adv),
                .is_conj_re (gi == 0),
                .op         (fp2_op_e'(in_op)),
                .x          (lane_x[gi]),
                .y          (lane_y[gi]),
                .d          (lane_d[gi])
            );
        end
    endgenerate

    assign out_valid = v_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign D1        = lane_d[0];
    assign D2        = lane_d[1];

endmodule

// File: tb/tb_fp2_addsub_pipe.sv
// Scoreboard bench for fp2_addsub_pipe: directed vectors on an 8-bit P=251
// instance plus one full-width SQIsign vector on a default instance.
module tb_fp2_addsub_pipe;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, DBL = 2'b10, CONJ = 2'b11;

    logic clk;
    logic rst;

    // small instance (WIDTH=8, P=251, TAG_W=4)
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [1:0] s_in_op;
    logic [3:0] s_in_tag, s_out_tag;
    logic [7:0] s_a1, s_a2, s_b1, s_b2, s_d1, s_d2;

    // default-parameter instance
    logic         l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic [1:0]   l_in_op;
    logic [7:0]   l_in_tag, l_out_tag;
    logic [254:0] l_a1, l_a2, l_b1, l_b2, l_d1, l_d2;

    typedef struct {
        logic [3:0] tag;
        logic [7:0] d1;
        logic [7:0] d2;
    } s_exp_t;

    typedef struct {
        logic [7:0]   tag;
        logic [254:0] d1;
        logic [254:0] d2;
    } l_exp_t;

    s_exp_t sb[$];
    l_exp_t lq[$];

    int n_chk = 0;
    int n_bad = 0;

    fp2_addsub_pipe #(.WIDTH(8), .P(8'd251), .TAG_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op), .in_tag(s_in_tag),
        .A1(s_a1), .A2(s_a2), .B1(s_b1), .B2(s_b2),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_tag(s_out_tag),
        .D1(s_d1), .D2(s_d2)
    );

    fp2_addsub_pipe dut_l (
        .clk(clk), .rst(rst),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_op(l_in_op), .in_tag(l_in_tag),
        .A1(l_a1), .A2(l_a2), .B1(l_b1), .B2(l_b2),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_tag(l_out_tag),
        .D1(l_d1), .D2(l_d2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Presents one bundle and holds it until accepted. Call just after a rising
    // edge; returns just after the accepting edge with in_valid dropped.
    task automatic send_s(input logic [1:0] op, input logic [3:0] tag,
                          input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] e1, input logic [7:0] e2);
        s_exp_t e;
        int     waited;
        bit     taken;
        waited = 0;
        taken  = 1'b0;
        s_in_valid = 1'b1;
        s_in_op = op; s_in_tag = tag;
        s_a1 = a1; s_a2 = a2; s_b1 = b1; s_b2 = b2;
        while (!taken && waited <= 50) begin
            @(negedge clk);
            if (s_in_ready) begin
                e.tag = tag; e.d1 = e1; e.d2 = e2;
                sb.push_back(e);
                taken = 1'b1;
                $display("in  tag=%0d op=%0d A=(%0d,%0d) B=(%0d,%0d)", tag, op, a1, a2, b1, b2);
            end else begin
                waited++;
            end
        end
        if (!taken) begin
            n_chk++;
            n_bad++;
            $display("FAIL send_timeout: tag %0d got in_ready=0 want 1 within 50 cycles", tag);
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    // Small-instance monitor: pops on every output transfer and checks that a
    // stalled output holds its contents.
    initial begin : mon_s
        s_exp_t     e;
        bit         stall_prev;
        logic [3:0] p_tag;
        logic [7:0] p_d1, p_d2;
        stall_prev = 1'b0;
        p_tag = '0; p_d1 = '0; p_d2 = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && rst) begin
                n_chk++;
                if (!(s_out_valid === 1'b1 && s_out_tag === p_tag && s_d1 === p_d1 && s_d2 === p_d2)) begin
                    n_bad++;
                    $display("FAIL hold: got v=%0b tag=%0d D=(%0d,%0d) want v=1 tag=%0d D=(%0d,%0d)",
                             s_out_valid, s_out_tag, s_d1, s_d2, p_tag, p_d1, p_d2);
                end
            end
            stall_prev = s_out_valid && !s_out_ready && rst;
            p_tag = s_out_tag; p_d1 = s_d1; p_d2 = s_d2;
            if (s_out_valid && s_out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got tag=%0d D=(%0d,%0d) want no output", s_out_tag, s_d1, s_d2);
                end else begin
                    e = sb.pop_front();
                    if (s_out_tag !== e.tag || s_d1 !== e.d1 || s_d2 !== e.d2) begin
                        n_bad++;
                        $display("FAIL result: got tag=%0d D=(%0d,%0d) want tag=%0d D=(%0d,%0d)",
                                 s_out_tag, s_d1, s_d2, e.tag, e.d1, e.d2);
                    end else begin
                        $display("out tag=%0d D=(%0d,%0d) ok", s_out_tag, s_d1, s_d2);
                    end
                end
            end
        end
    end

    initial begin : mon_l
        l_exp_t e;
        forever begin
            @(negedge clk);
            if (l_out_valid && l_out_ready) begin
                n_chk++;
                if (lq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out_l: got tag=%0d want no output", l_out_tag);
                end else begin
                    e = lq.pop_front();
                    if (l_out_tag !== e.tag || l_d1 !== e.d1 || l_d2 !== e.d2) begin
                        n_bad++;
                        $display("FAIL result_l: got tag=%0d D1=%h D2=%h want tag=%0d D1=%h D2=%h",
                                 l_out_tag, l_d1, l_d2, e.tag, e.d1, e.d2);
                    end else begin
                        $display("out_l tag=%0d D1=%h ok", l_out_tag, l_d1);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [254:0] lp;
        l_exp_t       le;
        int           w;

        rst = 1'b0;
        s_in_valid = 0; s_in_op = 0; s_in_tag = 0; s_a1 = 0; s_a2 = 0; s_b1 = 0; s_b2 = 0;
        s_out_ready = 1'b1;
        l_in_valid = 0; l_in_op = 0; l_in_tag = 0; l_a1 = 0; l_a2 = 0; l_b1 = 0; l_b2 = 0;
        l_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_d1", s_d1, 0);
        chk("rst_d2", s_d2, 0);
        chk("rst_tag", s_out_tag, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", s_in_ready, 1);

        // 1: ADD with wraparound on both lanes; result visible two cycles
        // after the cycle the bundle was presented.
        send_s(ADD, 4'd3, 8'd200, 8'd250, 8'd100, 8'd1, 8'd49, 8'd0);
        chk("lat1_mid_valid", s_out_valid, 0);
        @(posedge clk); #1;
        chk("lat1_out_valid", s_out_valid, 1);
        @(posedge clk); #1;

        // 2: SUB with borrow, then DBL back-to-back
        send_s(SUB, 4'd4, 8'd10, 8'd5, 8'd20, 8'd5, 8'd241, 8'd0);
        send_s(DBL, 4'd5, 8'd250, 8'd125, 8'd0, 8'd0, 8'd249, 8'd250);
        chk("b2b_first_valid", s_out_valid, 1);
        chk("b2b_first_tag", s_out_tag, 4);
        @(posedge clk); #1;
        chk("b2b_second_valid", s_out_valid, 1);
        chk("b2b_second_tag", s_out_tag, 5);
        @(posedge clk); #1;

        // 3: CONJ of zero and nonzero imaginary part
        send_s(CONJ, 4'd6, 8'd7, 8'd0, 8'd99, 8'd99, 8'd7, 8'd0);
        send_s(CONJ, 4'd7, 8'd7, 8'd9, 8'd0, 8'd0, 8'd7, 8'd242);
        send_s(SUB, 4'd8, 8'd0, 8'd250, 8'd250, 8'd0, 8'd1, 8'd250);
        repeat (3) @(posedge clk);
        #1;

        // 4: backpressure: out_ready low for 4 edges while tags 1..5 stream in
        fork
            begin
                send_s(ADD, 4'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd6);
                send_s(SUB, 4'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
                send_s(DBL, 4'd3, 8'd250, 8'd250, 8'd0, 8'd0, 8'd249, 8'd249);
                send_s(ADD, 4'd4, 8'd126, 8'd0, 8'd125, 8'd0, 8'd0, 8'd0);
                send_s(CONJ, 4'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
            end
            begin
                repeat (2) @(posedge clk);
                #2 s_out_ready = 1'b0;
                repeat (2) @(negedge clk);
                chk("stall_in_ready", s_in_ready, 0);
                chk("stall_out_valid", s_out_valid, 1);
                repeat (3) @(posedge clk);
                #2 s_out_ready = 1'b1;
            end
        join
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        chk("bp_drain", sb.size(), 0);
        #1;

        // 5: reset with two ops in flight
        send_s(ADD, 4'd9, 8'd3, 8'd3, 8'd4, 8'd4, 8'd7, 8'd7);
        send_s(SUB, 4'd10, 8'd9, 8'd9, 8'd1, 8'd1, 8'd8, 8'd8);
        chk("pre_rst_valid", s_out_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_valid", s_out_valid, 0);
        chk("mid_rst_d1", s_d1, 0);
        chk("mid_rst_d2", s_d2, 0);
        chk("mid_rst_tag", s_out_tag, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", s_in_ready, 1);
        send_s(ADD, 4'd11, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2);
        chk("lat5_mid_valid", s_out_valid, 0);
        @(posedge clk); #1;
        chk("lat5_out_valid", s_out_valid, 1);
        @(posedge clk); #1;

        // 6: full-width vector; imaginary lane exercises (P-1) + 1 = 0
        lp = (255'd5 << 248) - 255'd1;
        l_in_valid = 1'b1;
        l_in_op = ADD;
        l_in_tag = 8'hA5;
        l_a1 = 255'h3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b;
        l_b1 = 255'h127ba0471a1f3d76c58bca5bc731dd6f91ae57c60ea264fecde8b73482c3495;
        l_a2 = lp - 255'd1;
        l_b2 = 255'd1;
        @(negedge clk);
        chk("l_in_ready", l_in_ready, 1);
        le.tag = 8'hA5;
        le.d1  = 255'h4a838dcd027cc8b682e5f395dfed206022d9e5fe4c259f98f485ca61dd14b10;
        le.d2  = '0;
        lq.push_back(le);
        $display("in_l tag=%0d op=ADD", l_in_tag);
        @(posedge clk); #1;
        l_in_valid = 1'b0;
        chk("l_lat_mid_valid", l_out_valid, 0);
        @(posedge clk); #1;
        chk("l_lat_out_valid", l_out_valid, 1);

        w = 0;
        while ((sb.size() != 0 || lq.size() != 0) && w < 50) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        chk("final_drain", sb.size() + lq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fp2_addsub_pipe.md
Name: fp2_addsub_pipe

Overview:
- Parametrised, fully pipelined Fp2 add/subtract unit for the SQIsign datapath.
- Each element is x = x1 + x2·i over Fp, with p = P.
- Each lane computes modular A op B, with op selectable per transaction: ADD, SUB, DBL, CONJ.
- Sits between the Fp2 operand scheduler and the multiplier/inversion units.
- Replaces the fixed-width, no-handshake Fp2 adder with a valid/ready pipeline, a tag passthrough and an exposed latency constant.

Parameters:
- WIDTH, 255, bit width of one Fp element.
- P, fp_pkg::FP_P, field modulus; must satisfy 2 < P < 2^WIDTH.
- TAG_W, 8, width of the opaque transaction tag carried alongside the data.
- LATENCY (localparam), 2, cycles from accepted input to out_valid when not stalled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept the bundle this cycle.
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 DBL, 11 CONJ.
- in_tag  in  TAG_W  tag returned with the result.
- A1, A2  in  WIDTH  real and imaginary parts of operand A; each must be < P.
- B1, B2  in  WIDTH  real and imaginary parts of operand B; each must be < P; ignored for DBL and CONJ.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_tag  out  TAG_W  tag of the result.
- D1, D2  out  WIDTH  result real and imaginary parts, each in [0, P-1].

Behaviour:
- Reset (rst=0, asynchronous): both stage valid bits, out_valid, D1, D2 and out_tag clear to 0 immediately. An in-flight transaction is discarded, not replayed. in_ready is 1 from the first clock after rst deasserts.
- Handshake:
  - Input transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_valid and its data/tag hold stable until the output transfers.
- Stall: global enable adv = ~out_valid | out_ready. in_ready = adv, combinational from out_ready and out_valid only, never from in_valid.
  - adv=1: stage1 <= input (valid = in_valid & in_ready); stage2 <= stage1.
  - adv=0: both stages hold.
  - No bubbles are inserted; throughput is 1 op/cycle while out_ready=1.
- Latency: a transfer at edge k produces out_valid at edge k+2 if out_ready stays high. Order is strictly FIFO.
- Per-lane stage 1 (WIDTH+1-bit raw r, plus op):
  - ADD: r = x + y.
  - DBL: r = x + x.
  - SUB: r = x - y, with bit WIDTH as the borrow.
  - CONJ: lane 1 r = x passthrough; lane 2 r = 0 - x.
- Per-lane stage 2 reduction:
  - Additive ops (ADD, DBL): t = r - P over WIDTH+2 bits; D = t if t >= 0, else r.
  - Subtractive ops (SUB, CONJ lane 2): D = r + P (truncated to WIDTH) if borrow, else r.
  - CONJ lane 1: D = r.
- Boundaries:
  - x + y = P yields 0, never P.
  - 0 - 0 yields 0.
  - CONJ of A2 = 0 yields 0.
  - (P-1) + (P-1) yields P-2.
  - Operands >= P are outside the contract; results are unspecified but the handshake stays correct.
- Simultaneous stall release and new input: if out_ready rises in the same cycle in_valid is high, the input is accepted that cycle.

Decomposition:
- fp_pkg holds:
  - FP_W = 255 and FP_P (SQIsign level-1 prime, WIDTH bits).
  - typedef fp_t.
  - enum fp2_op_e {OP_ADD, OP_SUB, OP_DBL, OP_CONJ}.
  - FP2_ADDSUB_LATENCY = 2.
- Sub-module fp_addsub_lane: one Fp lane (stage-1 raw op plus stage-2 reduction registers), with an input is_conj_re selecting passthrough.
- fp2_addsub_pipe instantiates two lanes and owns the valid/tag pipeline and stall logic.

Test Plan (scenarios 1-5 use WIDTH=8, P=251, TAG_W=4):
1. ADD, A=(200,250), B=(100,1), tag=3 -> two cycles later out_valid=1, D=(49,0), out_tag=3.
2. SUB, A=(10,5), B=(20,5), followed back-to-back by DBL, A=(250,125) -> D=(241,0) then D=(249,250) on consecutive cycles.
3. CONJ, A=(7,0) then A=(7,9) -> D=(7,0), then D=(7,242).
4. Backpressure:
   - Stream tags 1..5 with out_ready held 0 for 4 cycles mid-stream.
   - Required: in_ready falls with the stall, D/out_tag hold stable, all 5 results exit in order with no loss or duplicate.
5. Reset mid-flight: assert rst with 2 ops in flight -> out_valid=0 and D=0 immediately. After release, a new ADD (1,1)+(1,1) returns (2,2) with latency 2.
6. Default parameters:
   - ADD A1=0x3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b, B1=0x127ba0471a1f3d76c58bca5bc731dd6f91ae57c60ea264fecde8b73482c3495.
   - Required D1=0x4a838dcd027cc8b682e5f395dfed206022d9e5fe4c259f98f485ca61dd14b10, after LATENCY cycles.
